// File: rtl/eth_tx_frame_arb.sv
// eth_tx_frame_arb: round-robin frame arbiter that merges S_COUNT AXI-stream
// sources into one MAC TX stream. A frame that stalls for too long is closed
// with a bad-frame marker, and the rest of that frame is discarded.
module eth_tx_frame_arb #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [S_COUNT-1:0]            s_axis_tready,

  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,

  input  logic                          cfg_enable,

  output logic                          status_grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    status_grant_index,
  output logic                          status_abort
);

  localparam int IDX_W = $clog2(S_COUNT);
  // After reset the first round-robin search starts at port 0.
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(S_COUNT - 1);
  // A TIMEOUT of zero turns the stall abort off entirely.
  localparam bit          ABORT_EN    = (TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [15:0] STALL_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ABORT,
    ST_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              abort_q, abort_d;
  // Goes high one clock after reset is released. Grants wait for it, so no
  // grant can be made on the first edge after reset.
  logic              armed_q, armed_d;

  // Per-source data unpacked for a clean grant-indexed mux.
  logic [DATA_WIDTH-1:0] src_data [S_COUNT];

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_user;

  logic                  rr_found;
  logic [IDX_W-1:0]      rr_idx;
  int                    rr_cand;
  logic [IDX_W-1:0]      rr_cand_idx;

  genvar gi;
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_unpack
      assign src_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign sel_data  = src_data[grant_q];
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_user  = s_axis_tuser[grant_q];

  // Round-robin search: first requesting port after the last one granted.
  always_comb begin
    rr_found    = 1'b0;
    rr_idx      = '0;
    rr_cand     = 0;
    rr_cand_idx = '0;
    for (int i = 1; i <= S_COUNT; i++) begin
      rr_cand     = (int'(last_grant_q) + i) % S_COUNT;
      rr_cand_idx = IDX_W'(rr_cand);
      if (!rr_found && s_axis_tvalid[rr_cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand_idx;
      end
    end
  end

  // Next-state logic and stream outputs for the frame FSM.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    stall_cnt_d    = stall_cnt_q;
    abort_d        = 1'b0;
    armed_d        = 1'b1;
    s_axis_tready  = '0;
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_cnt_d = '0;
        if (armed_q && cfg_enable && rr_found) begin
          grant_d      = rr_idx;
          last_grant_d = rr_idx;
          state_d      = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        m_axis_tdata           = sel_data;
        m_axis_tvalid          = sel_valid;
        m_axis_tlast           = sel_last;
        m_axis_tuser           = sel_user;
        s_axis_tready[grant_q] = m_axis_tready;
        // Only a silent source counts as a stall. Downstream backpressure
        // does not count, and the counter saturates instead of wrapping.
        if (sel_valid) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (sel_valid && m_axis_tready && sel_last) begin
          state_d = ST_IDLE;
        end else if (ABORT_EN && !sel_valid && (stall_cnt_d >= TIMEOUT_CNT)) begin
          state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        // Close the frame downstream with a zero byte flagged bad.
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        stall_cnt_d   = '0;
        if (m_axis_tready) begin
          abort_d = 1'b1;
          state_d = ST_DROP;
        end
      end

      ST_DROP: begin
        // Take the rest of the aborted frame from the source and discard it.
        s_axis_tready[grant_q] = 1'b1;
        stall_cnt_d            = '0;
        if (sel_valid && sel_last) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_INIT;
      stall_cnt_q  <= '0;
      abort_q      <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
      abort_q      <= abort_d;
      armed_q      <= armed_d;
    end
  end

  assign status_grant_valid = (state_q != ST_IDLE);
  assign status_grant_index = grant_q;
  assign status_abort       = abort_q;

endmodule

// File: doc/eth_tx_frame_arb.md
ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

Interface
REQ-001 SHALL have parameter S_COUNT, default 2: number of source ports, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: AXI-stream byte lane width feeding the MAC TX FIFO.
REQ-003 SHALL have parameter TIMEOUT, default 1024: stall cycles before forced abort; 0 disables abort, max 65535.
REQ-004 SHALL have clock and reset as follows: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port rst  input  1  async active-high reset.
REQ-007 SHALL have port s_axis_tdata  input  S_COUNT*DATA_WIDTH  packed source data, port n at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have ports s_axis_tvalid, s_axis_tlast, s_axis_tuser  input  S_COUNT  per-source valid/last/bad-frame flags.
REQ-009 SHALL have port s_axis_tready  output  S_COUNT  per-source ready.
REQ-010 SHALL have ports m_axis_tdata  output  DATA_WIDTH; m_axis_tvalid, m_axis_tlast, m_axis_tuser  output  1; m_axis_tready  input  1: merged stream to TX FIFO.
REQ-011 SHALL have port cfg_enable  input  1  permits new grants.
REQ-012 SHALL have ports status_grant_valid  output  1, status_grant_index  output  $clog2(S_COUNT): current owner.
REQ-013 SHALL have port status_abort  output  1  one-cycle pulse per forced abort.

Function
REQ-014 SHALL implement states IDLE, ACTIVE, ABORT, DROP.
REQ-015 IDLE: if cfg_enable=1 and any s_axis_tvalid=1, SHALL grant round-robin starting at (last_grant+1) mod S_COUNT, register grant, go ACTIVE next cycle; last_grant resets to S_COUNT-1 so port 0 wins first.
REQ-016 IDLE: all s_axis_tready=0, m_axis_tvalid=0.
REQ-017 ACTIVE: m_axis_tdata/tvalid/tlast/tuser SHALL be combinational mux of granted source; s_axis_tready[grant]=m_axis_tready, all others 0.
REQ-018 ACTIVE: transfer (m_axis_tvalid & m_axis_tready) with tlast=1 SHALL return to IDLE; minimum one IDLE cycle between frames.
REQ-019 Grant SHALL never change mid-frame; cfg_enable=0 mid-frame SHALL NOT interrupt the current frame.
REQ-020 Stall counter (16 bit) SHALL increment each ACTIVE cycle with s_axis_tvalid[grant]=0, clear on any cycle with it 1; downstream backpressure (m_axis_tready=0) SHALL NOT count.
REQ-021 TIMEOUT>0 and counter reaching TIMEOUT SHALL move to ABORT next cycle; counter saturates, never wraps.
REQ-022 ABORT: m_axis_tvalid=1, tdata=0, tlast=1, tuser=1; all s_axis_tready=0; on m_axis_tready=1 SHALL pulse status_abort one cycle and go DROP.
REQ-023 DROP: s_axis_tready[grant]=1, m_axis_tvalid=0; discard beats; accepted beat with tlast=1 SHALL go IDLE.
REQ-024 status_grant_valid=1 in ACTIVE, ABORT, DROP; status_grant_index = registered grant.
REQ-025 last_grant SHALL update on every grant so a source cannot win twice consecutively while another waits.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, counter 0, last_grant S_COUNT-1, all s_axis_tready 0, m_axis_tvalid/tlast/tuser 0, status outputs 0.
REQ-027 Reset mid-frame SHALL truncate output without tlast; no abort marker generated.
REQ-028 First grant SHALL occur no earlier than second rising clk edge after rst deasserts.

Verification
REQ-029 Both sources valid, 4-byte frames, m_axis_tready=1 -> output order port0,port1,port0,port1, each frame contiguous, one idle cycle between.
REQ-030 Port1 frame of 10 bytes, m_axis_tready toggled 50% -> bytes/tlast intact, port0 tready stays 0 throughout.
REQ-031 TIMEOUT=8, port0 stops tvalid after byte 3 of 10 -> after 8 stall cycles output byte 0x00 tlast=1 tuser=1, status_abort pulse, remaining 7 port0 bytes consumed silently, then IDLE.
REQ-032 TIMEOUT=8, m_axis_tready=0 for 100 cycles mid-frame with source valid -> no abort, frame completes.
REQ-033 cfg_enable=0 during port0 frame -> frame completes, no further grants while low; raising it resumes at port1.
REQ-034 rst asserted mid-frame on byte 5 -> same cycle s_axis_tready=0, m_axis_tvalid=0; after release port0 wins first.
